midi_voice_alloc: RTL and testbench

Voice allocator for the MIDI keyboard path. It accepts decoded note-on/note-off events from the MIDI receive core and assigns each note to one of NUM_VOICES synthesizer voices. It drives the per-voice gate, note and velocity registers consumed by the tone generators. It also exposes voice status and an all-notes-off control on the standard MMIO slot interface.

---
 rtl/midi_pkg.sv | 21 ++
 rtl/midi_voice_slot.sv | 66 ++++++
 rtl/midi_voice_alloc.sv | 191 +++++++++++++++++++
 tb/tb_midi_voice_alloc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg
// Shared types and constants for the MIDI voice allocator.
//   alloc_state_t : allocator FSM states (IDLE, SCAN, COMMIT)
//   NOTE_W, VEL_W : MIDI note / velocity widths
//   ADDR_*        : slot register addresses
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_CTRL   = 5'd1;
  localparam logic [4:0] ADDR_VOICE0 = 5'd2;

endpackage

// File: rtl/midi_voice_slot.sv
// midi_voice_slot
// State for one synthesizer voice: gate, note, velocity and a saturating age.
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   do_clear                  : all-notes-off (gate=0, age=0, no trig)
//   do_assign                 : new note (gate=1, note, vel, age=0, trig)
//   do_retrig                 : same note struck again (vel, age=0, trig)
//   do_release                : note-off (gate=0, note/vel/age kept)
//   do_age                    : age+1 if gated, saturating
//   note_in, vel_in           : values for assign/retrigger
//   gate, note, vel, age, trig: voice state; trig is a one-cycle pulse
module midi_voice_slot
  import midi_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              do_clear,
  input  logic              do_assign,
  input  logic              do_retrig,
  input  logic              do_release,
  input  logic              do_age,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [VEL_W-1:0]  vel_in,
  output logic              gate,
  output logic [NOTE_W-1:0] note,
  output logic [VEL_W-1:0]  vel,
  output logic [AGE_W-1:0]  age,
  output logic              trig
);

  // Commands are mutually exclusive in practice; the priority chain only
  // makes the intent explicit. trig defaults low so it never lasts longer
  // than the cycle following an assign or retrigger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate <= 1'b0;
      note <= '0;
      vel  <= '0;
      age  <= '0;
      trig <= 1'b0;
    end else begin
      trig <= 1'b0;
      if (do_clear) begin
        gate <= 1'b0;
        age  <= '0;
      end else if (do_assign) begin
        gate <= 1'b1;
        note <= note_in;
        vel  <= vel_in;
        age  <= '0;
        trig <= 1'b1;
      end else if (do_retrig) begin
        vel  <= vel_in;
        age  <= '0;
        trig <= 1'b1;
      end else if (do_release) begin
        gate <= 1'b0;
      end else if (do_age && gate && (age != '1)) begin
        age <= age + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc
// Assigns decoded MIDI note-on/off events to NUM_VOICES voices. Each event is
// scanned one voice per cycle, then committed (retrigger, free assign or steal
// of the oldest voice). Status and all-notes-off are on the MMIO slot.
// Ports:
//   clk, reset_n                        : clock, async active-low reset
//   ev_valid/ev_ready, ev_on/note/vel   : event handshake and payload
//   voice_gate/note/vel/trig            : per-voice outputs (packed)
//   cs, read, write, addr, wr_data      : slot strobes and write data
//   rd_data                             : combinational slot read data
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_trig,
  input  logic                         cs,
  input  logic                         read,
  input  logic                         write,
  input  logic [4:0]                   addr,
  input  logic [31:0]                  wr_data,
  output logic [31:0]                  rd_data
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t state, state_next;

  logic [IDX_W-1:0]  scan_idx;
  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic [VEL_W-1:0]  vel_q;

  logic              match_found, free_found;
  logic [IDX_W-1:0]  match_idx, free_idx, oldest_idx;
  logic [AGE_W-1:0]  oldest_age;

  logic [7:0]        steal_cnt;
  logic              panic_pend;

  logic [NOTE_W-1:0] slot_note [NUM_VOICES];
  logic [VEL_W-1:0]  slot_vel  [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];

  logic              handshake, panic_wr, steal_clr, panic_exec;
  logic              commit_on, commit_off, stealing, scan_first;
  logic [IDX_W-1:0]  target;
  logic              unused_wr_bits;

  assign unused_wr_bits = ^wr_data[31:2];

  assign ev_ready  = (state == IDLE) && !panic_pend;
  assign handshake = ev_valid && ev_ready;
  assign panic_wr  = cs && write && (addr == ADDR_CTRL) && wr_data[0];
  assign steal_clr = cs && write && (addr == ADDR_CTRL) && wr_data[1];

  // A panic requested together with a handshake is deferred so the
  // accepted event still completes; otherwise IDLE clears immediately.
  assign panic_exec = (state == IDLE) && (panic_pend || (panic_wr && !handshake));

  assign commit_on  = (state == COMMIT) && on_q;
  assign commit_off = (state == COMMIT) && !on_q;
  assign stealing   = commit_on && !match_found && !free_found;
  assign target     = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
  assign scan_first = (scan_idx == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Event latch and scan trackers. On the first scanned voice each tracker is
  // overwritten so stale results from the previous event never leak through.
  // Oldest uses a strict compare so ties stay with the lower index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx    <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      vel_q       <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      oldest_age  <= '0;
    end else if (handshake) begin
      scan_idx <= '0;
      on_q     <= ev_on && (ev_vel != '0);
      note_q   <= ev_note;
      vel_q    <= ev_vel;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + IDX_W'(1);
      if (scan_first || !match_found) begin
        match_found <= voice_gate[scan_idx] && (slot_note[scan_idx] == note_q);
        match_idx   <= scan_idx;
      end
      if (scan_first || !free_found) begin
        free_found <= !voice_gate[scan_idx];
        free_idx   <= scan_idx;
      end
      if (scan_first || (slot_age[scan_idx] > oldest_age)) begin
        oldest_age <= slot_age[scan_idx];
        oldest_idx <= scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steal_cnt  <= '0;
      panic_pend <= 1'b0;
    end else begin
      if (steal_clr)
        steal_cnt <= '0;
      else if (stealing && (steal_cnt != 8'hFF))
        steal_cnt <= steal_cnt + 8'd1;

      if (panic_exec)
        panic_pend <= 1'b0;
      else if (panic_wr)
        panic_pend <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    midi_voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .do_clear   (panic_exec),
      .do_assign  (commit_on && !match_found && (target == IDX_W'(i))),
      .do_retrig  (commit_on && match_found && (match_idx == IDX_W'(i))),
      .do_release (commit_off && match_found && (match_idx == IDX_W'(i))),
      .do_age     (commit_on && (target != IDX_W'(i))),
      .note_in    (note_q),
      .vel_in     (vel_q),
      .gate       (voice_gate[i]),
      .note       (voice_note[i*NOTE_W +: NOTE_W]),
      .vel        (voice_vel[i*VEL_W +: VEL_W]),
      .age        (slot_age[i]),
      .trig       (voice_trig[i])
    );
    assign slot_note[i] = voice_note[i*NOTE_W +: NOTE_W];
    assign slot_vel[i]  = voice_vel[i*VEL_W +: VEL_W];
  end

  // Slot read mux; voice registers occupy ADDR_VOICE0 upward, everything
  // else (including the write-only control address) reads as zero.
  always_comb begin
    rd_data = '0;
    if (cs && read) begin
      if (addr == ADDR_STATUS) begin
        rd_data[7:0]  = 8'(voice_gate);
        rd_data[15:8] = steal_cnt;
        rd_data[16]   = (state != IDLE);
        rd_data[17]   = panic_pend;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (addr == ADDR_VOICE0 + 5'(i)) begin
          rd_data[6:0]   = slot_note[i];
          rd_data[14:8]  = slot_vel[i];
          rd_data[16]    = voice_gate[i];
          rd_data[31:24] = 8'(slot_age[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc
// Directed self-checking bench for midi_voice_alloc with NUM_VOICES=4.
module tb_midi_voice_alloc;

  localparam int N = 4;

  logic            clk;
  logic            reset_n;
  logic            ev_valid;
  logic            ev_ready;
  logic            ev_on;
  logic [6:0]      ev_note;
  logic [6:0]      ev_vel;
  logic [N-1:0]    voice_gate;
  logic [7*N-1:0]  voice_note;
  logic [7*N-1:0]  voice_vel;
  logic [N-1:0]    voice_trig;
  logic            cs;
  logic            read;
  logic            write;
  logic [4:0]      addr;
  logic [31:0]     wr_data;
  logic [31:0]     rd_data;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] trig_now, trig_late;
  logic         ready_now, ready_late;
  logic [31:0]  status_commit, status_now, status_late;
  logic [31:0]  rd_val;
  logic [6:0]   seq_notes [4];

  midi_voice_alloc #(.NUM_VOICES(N), .AGE_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .ev_vel     (ev_vel),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .voice_trig (voice_trig),
    .cs         (cs),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Sends one event starting at a negedge, optionally pulsing an all-notes-off
  // write in cycle panic_cycle (0 = handshake cycle). Captures status in the
  // COMMIT cycle and outputs in the two cycles after it.
  task automatic applyStimulus(input logic on, input logic [6:0] note,
                               input logic [6:0] vel, input int panic_cycle);
    int   wait_cnt = 0;
    logic ready_seen = 1'b0;
    while (!ev_ready && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("ready_wait", 32'(ev_ready), 32'h1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    ev_vel   = vel;
    if (panic_cycle == 0) begin
      write = 1'b1; addr = 5'd1; wr_data = 32'h1;
    end
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      ev_valid = 1'b0;
      ev_on    = ~on;
      ev_note  = 7'h7F;
      ev_vel   = 7'h7F;
      write = 1'b0; addr = 5'd0; wr_data = 32'h0;
      if (ev_ready) ready_seen = 1'b1;
      if (k == N + 1) status_commit = rd_data;
      if (k == panic_cycle) begin
        write = 1'b1; addr = 5'd1; wr_data = 32'h1;
      end
    end
    checkOutput("ready_low_busy", 32'(ready_seen), 32'h0);
    @(negedge clk);
    trig_now = voice_trig; ready_now = ev_ready; status_now = rd_data;
    @(negedge clk);
    trig_late = voice_trig; ready_late = ev_ready; status_late = rd_data;
    checkOutput("trig_one_cycle", 32'(trig_late), 32'h0);
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
    addr = 5'd0;
  endtask

  task automatic writeCtrl(input logic [31:0] d);
    write = 1'b1; addr = 5'd1; wr_data = d;
    @(negedge clk);
    write = 1'b0; addr = 5'd0; wr_data = 32'h0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = 5'd0; wr_data = 32'h0;
    ev_valid = 1'b0; ev_on = 1'b0; ev_note = 7'd0; ev_vel = 7'd0;
    reset_n = 1'b0;
    seq_notes = '{7'd60, 7'd62, 7'd64, 7'd65};

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(ev_ready), 32'h1);
    checkOutput("reset_gate", 32'(voice_gate), 32'h0);
    checkOutput("reset_trig", 32'(voice_trig), 32'h0);
    checkOutput("reset_status", rd_data, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single note-on lands on voice 0.
    applyStimulus(1'b1, 7'd60, 7'd100, -1);
    checkOutput("t1_trig", 32'(trig_now), 32'h1);
    checkOutput("t1_ready_back", 32'(ready_now), 32'h1);
    checkOutput("t1_gate", 32'(voice_gate), 32'h1);
    checkOutput("t1_note", 32'(voice_note[6:0]), 32'd60);
    checkOutput("t1_vel", 32'(voice_vel[6:0]), 32'd100);

    // All-notes-off from IDLE clears on the next edge.
    writeCtrl(32'h1);
    checkOutput("idle_panic_gate", 32'(voice_gate), 32'h0);

    // Fill all voices, then steal the oldest.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, seq_notes[i], 7'd100, -1);
      checkOutput("t2_fill_trig", 32'(trig_now), 32'(1 << i));
    end
    applyStimulus(1'b1, 7'd67, 7'd100, -1);
    checkOutput("t2_steal_trig", 32'(trig_now), 32'h1);
    checkOutput("t2_status", status_now, 32'h0000_010F);
    checkOutput("t2_note0", 32'(voice_note[6:0]), 32'd67);
    readReg(5'd2, rd_val);
    checkOutput("t2_voice0", rd_val, 32'h0001_6443);
    readReg(5'd3, rd_val);
    checkOutput("t2_voice1", rd_val, 32'h0301_643E);
    readReg(5'd5, rd_val);
    checkOutput("t2_voice3", rd_val, 32'h0101_6441);
    readReg(5'd6, rd_val);
    checkOutput("t2_unmapped", rd_val, 32'h0);

    // Panic plus steal counter clear; notes and velocities survive.
    writeCtrl(32'h3);
    checkOutput("t2_clear_status", rd_data, 32'h0);
    readReg(5'd2, rd_val);
    checkOutput("t2_clear_voice0", rd_val, 32'h0000_6443);

    // Same note twice: retrigger on voice 0 only.
    applyStimulus(1'b1, 7'd60, 7'd80, -1);
    checkOutput("t3_trig_a", 32'(trig_now), 32'h1);
    applyStimulus(1'b1, 7'd60, 7'd40, -1);
    checkOutput("t3_trig_b", 32'(trig_now), 32'h1);
    checkOutput("t3_gate", 32'(voice_gate), 32'h1);
    readReg(5'd2, rd_val);
    checkOutput("t3_voice0", rd_val, 32'h0001_283C);

    // Note-off releases; vel-0 note-on is a no-op.
    applyStimulus(1'b0, 7'd60, 7'd0, -1);
    checkOutput("t4_off_trig", 32'(trig_now), 32'h0);
    checkOutput("t4_off_gate", 32'(voice_gate), 32'h0);
    readReg(5'd2, rd_val);
    checkOutput("t4_off_voice0", rd_val, 32'h0000_283C);
    applyStimulus(1'b1, 7'd60, 7'd0, -1);
    checkOutput("t4_vel0_trig", 32'(trig_now), 32'h0);
    checkOutput("t4_vel0_gate", 32'(voice_gate), 32'h0);

    // Panic requested mid-scan is deferred until after COMMIT.
    applyStimulus(1'b1, 7'd70, 7'd90, 2);
    checkOutput("t5_commit_status", status_commit, 32'h0003_0000);
    checkOutput("t5_trig", 32'(trig_now), 32'h1);
    checkOutput("t5_ready_pend", 32'(ready_now), 32'h0);
    checkOutput("t5_status_pend", status_now, 32'h0002_0001);
    checkOutput("t5_ready_late", 32'(ready_late), 32'h1);
    checkOutput("t5_status_late", status_late, 32'h0);

    // Panic coinciding with the handshake.
    applyStimulus(1'b1, 7'd72, 7'd50, 0);
    checkOutput("t5b_commit_status", status_commit, 32'h0003_0000);
    checkOutput("t5b_trig", 32'(trig_now), 32'h1);
    checkOutput("t5b_status_late", status_late, 32'h0);

    // Reset during SCAN aborts the event.
    applyStimulus(1'b1, 7'd60, 7'd100, -1);
    checkOutput("t6_pre_gate", 32'(voice_gate), 32'h1);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd62; ev_vel = 7'd100;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_gate", 32'(voice_gate), 32'h0);
    checkOutput("t6_rst_trig", 32'(voice_trig), 32'h0);
    checkOutput("t6_rst_ready", 32'(ev_ready), 32'h1);
    checkOutput("t6_rst_notes", 32'(voice_note), 32'h0);
    checkOutput("t6_rst_vels", 32'(voice_vel), 32'h0);
    checkOutput("t6_rst_status", rd_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 7'd64, 7'd30, -1);
    checkOutput("t6_after_trig", 32'(trig_now), 32'h1);
    checkOutput("t6_after_note", 32'(voice_note[6:0]), 32'd64);
    checkOutput("t6_after_gate", 32'(voice_gate), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
